// File: rtl/systolic_pe.sv
// Weight-stationary systolic PE: registered MAC with a double-buffered weight loaded over a daisy-chained shadow path.
// Optional SYSTOLIC_PE_SAT_EN: saturating accumulate plus a sticky sat_flag output; default build wraps.
module systolic_pe #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WEIGHT_W = 16,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DATA_W-1:0]   act_in,
  input  logic                act_valid_in,
  input  logic [ACC_W-1:0]    psum_in,
  output logic [DATA_W-1:0]   act_out,
  output logic                act_valid_out,
  output logic [ACC_W-1:0]    psum_out,
  input  logic                wshift_en,
  input  logic [WEIGHT_W-1:0] wshift_in,
  output logic [WEIGHT_W-1:0] wshift_out,
  input  logic                wcommit,
`ifdef SYSTOLIC_PE_SAT_EN
  output logic                sat_flag,
`endif
  output logic [WEIGHT_W-1:0] weight_active
);

  localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

  // The accumulator must hold a full-precision product.
  generate
    if (ACC_W < PROD_W) begin : g_acc_w_check
      $error("systolic_pe: ACC_W must be >= DATA_W + WEIGHT_W");
    end
  endgenerate

  logic [DATA_W-1:0]   act_q, act_d;
  logic                valid_q, valid_d;
  logic [ACC_W-1:0]    psum_q, psum_d;
  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] weight_q, weight_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_wrap;
  logic [ACC_W-1:0]         mac_res;

`ifdef SYSTOLIC_PE_SAT_EN
  logic sat_q, sat_d;
  logic ovf;
`endif

  // MAC arithmetic: full-precision signed product, sign-extended, ACC_W-bit sum.
  always_comb begin
    prod     = PROD_W'($signed(act_in) * $signed(weight_q));
    prod_ext = ACC_W'(prod);
    sum_wrap = prod_ext + $signed(psum_in);
`ifdef SYSTOLIC_PE_SAT_EN
    // Overflow when both addends share a sign that the result does not.
    ovf = (prod_ext[ACC_W-1] == psum_in[ACC_W-1]) && (sum_wrap[ACC_W-1] != psum_in[ACC_W-1]);
    if (ovf) begin
      mac_res = psum_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac_res = sum_wrap;
    end
`else
    mac_res = sum_wrap;
`endif
  end

  // Next-state for datapath and weight chain; the chain ignores en.
  always_comb begin
    act_d    = act_q;
    valid_d  = valid_q;
    psum_d   = psum_q;
    shadow_d = shadow_q;
    weight_d = weight_q;
`ifdef SYSTOLIC_PE_SAT_EN
    sat_d    = sat_q;
`endif
    if (en) begin
      act_d   = act_in;
      valid_d = act_valid_in;
      psum_d  = act_valid_in ? mac_res : psum_in;
`ifdef SYSTOLIC_PE_SAT_EN
      if (act_valid_in && ovf) begin
        sat_d = 1'b1;
      end
`endif
    end
    if (wshift_en) begin
      shadow_d = wshift_in;
    end
    if (wcommit) begin
      weight_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q    <= '0;
      valid_q  <= 1'b0;
      psum_q   <= '0;
      shadow_q <= '0;
      weight_q <= '0;
`ifdef SYSTOLIC_PE_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      act_q    <= act_d;
      valid_q  <= valid_d;
      psum_q   <= psum_d;
      shadow_q <= shadow_d;
      weight_q <= weight_d;
`ifdef SYSTOLIC_PE_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign act_out       = act_q;
  assign act_valid_out = valid_q;
  assign psum_out      = psum_q;
  assign wshift_out    = shadow_q;
  assign weight_active = weight_q;
`ifdef SYSTOLIC_PE_SAT_EN
  assign sat_flag      = sat_q;
`endif

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe (default 16/16/32 configuration).
// Expected values are hand-computed; SYSTOLIC_PE_SAT_EN selects the saturating expectations.
module tb_systolic_pe;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WEIGHT_W = 16;
  localparam int unsigned ACC_W    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [DATA_W-1:0]   act_in;
  logic                act_valid_in;
  logic [ACC_W-1:0]    psum_in;
  logic [DATA_W-1:0]   act_out;
  logic                act_valid_out;
  logic [ACC_W-1:0]    psum_out;
  logic                wshift_en;
  logic [WEIGHT_W-1:0] wshift_in;
  logic [WEIGHT_W-1:0] wshift_out;
  logic                wcommit;
  logic [WEIGHT_W-1:0] weight_active;
`ifdef SYSTOLIC_PE_SAT_EN
  logic                sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  systolic_pe #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .act_in        (act_in),
    .act_valid_in  (act_valid_in),
    .psum_in       (psum_in),
    .act_out       (act_out),
    .act_valid_out (act_valid_out),
    .psum_out      (psum_out),
    .wshift_en     (wshift_en),
    .wshift_in     (wshift_in),
    .wshift_out    (wshift_out),
    .wcommit       (wcommit),
`ifdef SYSTOLIC_PE_SAT_EN
    .sat_flag      (sat_flag),
`endif
    .weight_active (weight_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".act_out"}, 32'(act_out), 32'h0);
    check({tag, ".act_valid_out"}, 32'(act_valid_out), 32'h0);
    check({tag, ".psum_out"}, psum_out, 32'h0);
    check({tag, ".wshift_out"}, 32'(wshift_out), 32'h0);
    check({tag, ".weight_active"}, 32'(weight_active), 32'h0);
`ifdef SYSTOLIC_PE_SAT_EN
    check({tag, ".sat_flag"}, 32'(sat_flag), 32'h0);
`endif
  endtask

  // Shift one weight into the shadow, then commit it in a separate cycle.
  task automatic load_weight(input logic [WEIGHT_W-1:0] w);
    wshift_en = 1'b1; wshift_in = w; step();
    wshift_en = 1'b0; wcommit = 1'b1; step();
    wcommit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; act_in = '0; act_valid_in = 1'b0; psum_in = '0;
    wshift_en = 1'b0; wshift_in = '0; wcommit = 1'b0;
    step(); step();
    check_all_zero("reset");

    // Basic MAC with weight -1
    rst_n = 1'b1; en = 1'b1;
    load_weight(16'hFFFF);
    check("commit_neg1", 32'(weight_active), 32'h0000_FFFF);
    act_in = 16'd5; act_valid_in = 1'b1; psum_in = 32'd100; step();
    check("mac1.psum", psum_out, 32'd95);
    check("mac1.act", 32'(act_out), 32'd5);
    check("mac1.valid", 32'(act_valid_out), 32'd1);
    act_in = 16'hFFFD; psum_in = 32'd0; step();
    check("mac2.psum", psum_out, 32'd3);
    check("mac2.act", 32'(act_out), 32'h0000_FFFD);

    // Bypass
    act_in = 16'd11; act_valid_in = 1'b0; psum_in = 32'd42; step();
    check("bypass.psum", psum_out, 32'd42);
    check("bypass.valid", 32'(act_valid_out), 32'd0);

    // Stall while inputs change
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_in = 16'(20 + i); act_valid_in = 1'b1; psum_in = 32'(i + 1000); step();
      check("stall.psum", psum_out, 32'd42);
      check("stall.act", 32'(act_out), 32'd11);
      check("stall.valid", 32'(act_valid_out), 32'd0);
    end
    en = 1'b1; act_valid_in = 1'b0; psum_in = 32'd0;

    // Chain load and double buffer
    load_weight(16'd1);
    wshift_en = 1'b1; wshift_in = 16'd7; step();
    check("shift7", 32'(wshift_out), 32'd7);
    wshift_in = 16'd2; step();
    wshift_en = 1'b0;
    check("shift2", 32'(wshift_out), 32'd2);
    check("shift_keeps_active", 32'(weight_active), 32'd1);
    wcommit = 1'b1; act_in = 16'd4; act_valid_in = 1'b1; psum_in = 32'd0; step();
    wcommit = 1'b0;
    check("commit_mac.psum", psum_out, 32'd4);
    check("commit_mac.weight", 32'(weight_active), 32'd2);
    step();
    check("post_commit.psum", psum_out, 32'd8);
    act_valid_in = 1'b0;
    wshift_en = 1'b1; wcommit = 1'b1; wshift_in = 16'd9; step();
    wshift_en = 1'b0; wcommit = 1'b0;
    check("shift_commit.weight", 32'(weight_active), 32'd2);
    check("shift_commit.shadow", 32'(wshift_out), 32'd9);

    // Positive overflow: (-32768)*(-32768) + 0x40000000
    load_weight(16'h8000);
    act_in = 16'h8000; act_valid_in = 1'b1; psum_in = 32'h4000_0000; step();
`ifdef SYSTOLIC_PE_SAT_EN
    check("ovf_pos.psum", psum_out, 32'h7FFF_FFFF);
    check("ovf_pos.sat", 32'(sat_flag), 32'd1);
`else
    check("ovf_pos.psum", psum_out, 32'h8000_0000);
`endif
    act_in = 16'd1; psum_in = 32'd0; step();
    check("after_ovf.psum", psum_out, 32'hFFFF_8000);
`ifdef SYSTOLIC_PE_SAT_EN
    check("after_ovf.sat", 32'(sat_flag), 32'd1);
`endif

    // Reset mid-run with a valid MAC in flight
    act_in = 16'd3; psum_in = 32'd5; wshift_en = 1'b1; wshift_in = 16'd6; rst_n = 1'b0; step();
    wshift_en = 1'b0; rst_n = 1'b1; act_valid_in = 1'b0; act_in = '0; psum_in = '0;
    check_all_zero("mid_reset");

    // Negative overflow: (-32768)*32767 + 0x80000000
    load_weight(16'h7FFF);
    act_in = 16'h8000; act_valid_in = 1'b1; psum_in = 32'h8000_0000; step();
`ifdef SYSTOLIC_PE_SAT_EN
    check("ovf_neg.psum", psum_out, 32'h8000_0000);
    check("ovf_neg.sat", 32'(sat_flag), 32'd1);
`else
    check("ovf_neg.psum", psum_out, 32'h4000_8000);
`endif
    act_valid_in = 1'b0; psum_in = 32'h7FFF_FFFF; step();
    check("bypass_max.psum", psum_out, 32'h7FFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
